// File: rtl/asic_ram_transmit.sv
`default_nettype none
// ============================================================================
// Module      : asic_ram_transmit
// Description : Serialises 16-bit FIFO words MSB first onto the single-bit
//               ASIC RAM readout line, framed by an active-low TransmitOn
//               envelope. Words are prefetched so consecutive words leave the
//               line with no gap. Used as an ASIC emulator for loopback into
//               the DIF readout receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module asic_ram_transmit #(
  parameter int WORD_COUNT_WIDTH = 12,
  parameter int INVERT_DATA      = 1
) (
  input  logic                        Clk,
  input  logic                        reset,
  input  logic                        Start,
  input  logic [WORD_COUNT_WIDTH-1:0] FrameWords,
  input  logic [15:0]                 FifoData,
  input  logic                        FifoEmpty,
  output logic                        FifoReadEn,
  output logic                        AsicDout,
  output logic                        TransmitOn,
  output logic                        Busy,
  output logic                        TransmitDone,
  output logic                        Underrun,
  output logic [WORD_COUNT_WIDTH-1:0] WordsSent
);

  // Line polarity: the receiver re-inverts, so by default the line carries ~bit.
  localparam logic                        c_INV  = (INVERT_DATA != 0);
  localparam logic [WORD_COUNT_WIDTH-1:0] c_ZERO = '0;
  localparam logic [WORD_COUNT_WIDTH-1:0] c_ONE  = {{(WORD_COUNT_WIDTH-1){1'b0}}, 1'b1};

  // Bit positions inside a word that drive the prefetch pipeline.
  localparam logic [3:0] c_BIT_PREFETCH = 4'd12;  // decide; strobe is high during bit 13
  localparam logic [3:0] c_BIT_CAPTURE  = 4'd14;  // FIFO data valid, latch into next word
  localparam logic [3:0] c_BIT_LAST     = 4'd15;  // word boundary

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                        r_state;
  logic [15:0]                   r_shift;
  logic [15:0]                   r_nextWord;
  logic [3:0]                    r_bitCnt;
  logic [WORD_COUNT_WIDTH-1:0]   r_wordsLeft;   // includes the word currently on the line
  logic                          r_haveNext;    // a prefetched word will follow this one
  logic                          w_moreWords;

  // More words are owed after the one currently being shifted.
  assign w_moreWords = (r_wordsLeft > c_ONE);

  // Frame sequencer: state, shift datapath and all registered outputs.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= 16'h0000;
      r_nextWord   <= 16'h0000;
      r_bitCnt     <= 4'd0;
      r_wordsLeft  <= c_ZERO;
      r_haveNext   <= 1'b0;
      FifoReadEn   <= 1'b0;
      AsicDout     <= 1'b1;
      TransmitOn   <= 1'b1;
      Busy         <= 1'b0;
      TransmitDone <= 1'b0;
      Underrun     <= 1'b0;
      WordsSent    <= c_ZERO;
    end else begin
      // Strobes default low; each state raises them for exactly one cycle.
      FifoReadEn   <= 1'b0;
      TransmitDone <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (Start) begin
            Busy        <= 1'b1;
            Underrun    <= 1'b0;
            WordsSent   <= c_ZERO;
            r_wordsLeft <= FrameWords;
            r_bitCnt    <= 4'd0;
            r_haveNext  <= 1'b0;
            if (FrameWords == c_ZERO) begin
              r_state      <= S_DONE;
              TransmitDone <= 1'b1;
            end else if (FifoEmpty) begin
              r_state      <= S_DONE;
              TransmitDone <= 1'b1;
              Underrun     <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              FifoReadEn <= 1'b1;
            end
          end
        end

        // Read strobe is on the wire this cycle; data arrives next cycle.
        S_FETCH: begin
          r_state <= S_LOAD;
        end

        // First word: present its MSB on the line together with the envelope.
        S_LOAD: begin
          r_shift    <= FifoData;
          r_bitCnt   <= 4'd0;
          AsicDout   <= c_INV ^ FifoData[15];
          TransmitOn <= 1'b0;
          r_state    <= S_SHIFT;
        end

        S_SHIFT: begin
          r_bitCnt <= r_bitCnt + 4'd1;

          // Prefetch decision is latched once; later FifoEmpty changes are ignored.
          if (r_bitCnt == c_BIT_PREFETCH) begin
            r_haveNext <= w_moreWords && !FifoEmpty;
            FifoReadEn <= w_moreWords && !FifoEmpty;
          end

          if ((r_bitCnt == c_BIT_CAPTURE) && r_haveNext) begin
            r_nextWord <= FifoData;
          end

          if (r_bitCnt == c_BIT_LAST) begin
            WordsSent   <= WordsSent + c_ONE;
            r_wordsLeft <= r_wordsLeft - c_ONE;
            if (r_haveNext) begin
              r_shift    <= r_nextWord;
              AsicDout   <= c_INV ^ r_nextWord[15];
              r_haveNext <= 1'b0;
            end else begin
              // Either the last word or the FIFO ran dry: close the frame.
              r_state      <= S_DONE;
              TransmitOn   <= 1'b1;
              AsicDout     <= 1'b1;
              TransmitDone <= 1'b1;
              Underrun     <= w_moreWords;
            end
          end else begin
            r_shift  <= {r_shift[14:0], 1'b0};
            AsicDout <= c_INV ^ r_shift[14];
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          Busy    <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_asic_ram_transmit.sv
`default_nettype none
// ============================================================================
// Module      : tb_asic_ram_transmit
// Description : Directed self-checking bench for asic_ram_transmit with a
//               small behavioural FIFO (one-cycle read latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asic_ram_transmit;

  localparam int W = 12;

  logic         Clk;
  logic         reset;
  logic         Start;
  logic [W-1:0] FrameWords;
  logic [15:0]  FifoData;
  logic         FifoEmpty;
  logic         FifoReadEn;
  logic         AsicDout;
  logic         TransmitOn;
  logic         Busy;
  logic         TransmitDone;
  logic         Underrun;
  logic [W-1:0] WordsSent;

  int total;
  int bad;

  // FIFO model state
  logic [15:0] mem [0:63];
  int          wrPtr;
  int          rdPtr;
  int          rdPulses;

  asic_ram_transmit #(.WORD_COUNT_WIDTH(W), .INVERT_DATA(1)) dut (
    .Clk          (Clk),
    .reset        (reset),
    .Start        (Start),
    .FrameWords   (FrameWords),
    .FifoData     (FifoData),
    .FifoEmpty    (FifoEmpty),
    .FifoReadEn   (FifoReadEn),
    .AsicDout     (AsicDout),
    .TransmitOn   (TransmitOn),
    .Busy         (Busy),
    .TransmitDone (TransmitDone),
    .Underrun     (Underrun),
    .WordsSent    (WordsSent)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign FifoEmpty = (rdPtr == wrPtr);

  // FIFO read port: data valid the cycle after the strobe
  always @(posedge Clk) begin
    if (FifoReadEn) begin
      rdPulses = rdPulses + 1;
      if (rdPtr != wrPtr) begin
        FifoData <= mem[rdPtr];
        rdPtr = rdPtr + 1;
      end
    end
  end

  task automatic push(input logic [15:0] d);
    mem[wrPtr] = d;
    wrPtr = wrPtr + 1;
  endtask

  // Start pulse in cycle N; returns at the negedge of cycle N+1
  task automatic start_frame(input int n);
    @(negedge Clk);
    Start = 1'b1;
    FrameWords = W'(n);
    @(negedge Clk);
    Start = 1'b0;
    FrameWords = W'(4095);
  endtask

  // Waits for the envelope, collects line bits while low, returns at the first high cycle
  task automatic capture_frame(output int waitCyc, output int lowCyc, output logic [63:0] bits);
    waitCyc = 0;
    lowCyc = 0;
    bits = '0;
    while (TransmitOn !== 1'b0 && waitCyc < 12) begin
      @(negedge Clk);
      waitCyc++;
    end
    while (TransmitOn === 1'b0 && lowCyc < 80) begin
      bits = {bits[62:0], AsicDout};
      lowCyc++;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge Clk);
    total++; if (TransmitOn !== 1'b1 || AsicDout !== 1'b1) begin bad++; $display("FAIL reset_line TransmitOn=%b AsicDout=%b required 1 1", TransmitOn, AsicDout); end
    total++; if (Busy !== 1'b0 || TransmitDone !== 1'b0 || FifoReadEn !== 1'b0) begin bad++; $display("FAIL reset_ctrl Busy=%b Done=%b ReadEn=%b required 0 0 0", Busy, TransmitDone, FifoReadEn); end
    total++; if (Underrun !== 1'b0 || WordsSent !== '0) begin bad++; $display("FAIL reset_stat Underrun=%b WordsSent=%0d required 0 0", Underrun, WordsSent); end
    reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_single();
    int wc, lc, r0;
    logic [63:0] b;
    push(16'hA5C3);
    r0 = rdPulses;
    start_frame(1);
    total++; if (FifoReadEn !== 1'b1 || Busy !== 1'b1) begin bad++; $display("FAIL single_readen_N1 ReadEn=%b Busy=%b required 1 1", FifoReadEn, Busy); end
    @(negedge Clk);
    total++; if (FifoReadEn !== 1'b0 || TransmitOn !== 1'b1) begin bad++; $display("FAIL single_N2 ReadEn=%b TransmitOn=%b required 0 1", FifoReadEn, TransmitOn); end
    capture_frame(wc, lc, b);
    total++; if (wc !== 1) begin bad++; $display("FAIL single_latency wait=%0d required 1", wc); end
    total++; if (lc !== 16) begin bad++; $display("FAIL single_low low=%0d required 16", lc); end
    total++; if (b[15:0] !== 16'h5A3C) begin bad++; $display("FAIL single_bits got=%h required 5a3c", b[15:0]); end
    total++; if (TransmitDone !== 1'b1 || AsicDout !== 1'b1) begin bad++; $display("FAIL single_done Done=%b AsicDout=%b required 1 1", TransmitDone, AsicDout); end
    total++; if (WordsSent !== 12'd1 || Underrun !== 1'b0) begin bad++; $display("FAIL single_stat WordsSent=%0d Underrun=%b required 1 0", WordsSent, Underrun); end
    @(negedge Clk);
    total++; if (Busy !== 1'b0 || TransmitDone !== 1'b0) begin bad++; $display("FAIL single_idle Busy=%b Done=%b required 0 0", Busy, TransmitDone); end
    total++; if (rdPulses - r0 !== 1) begin bad++; $display("FAIL single_reads reads=%0d required 1", rdPulses - r0); end
  endtask

  task automatic test_back_to_back();
    int wc, lc, r0;
    logic [63:0] b;
    push(16'hFFFF); push(16'h0000); push(16'h8001);
    r0 = rdPulses;
    start_frame(3);
    capture_frame(wc, lc, b);
    total++; if (lc !== 48) begin bad++; $display("FAIL b2b_low low=%0d required 48", lc); end
    total++; if (b[47:0] !== 48'h0000_FFFF_7FFE) begin bad++; $display("FAIL b2b_bits got=%h required 0000ffff7ffe", b[47:0]); end
    total++; if (TransmitDone !== 1'b1 || WordsSent !== 12'd3 || Underrun !== 1'b0) begin bad++; $display("FAIL b2b_done Done=%b WordsSent=%0d Underrun=%b required 1 3 0", TransmitDone, WordsSent, Underrun); end
    total++; if (rdPulses - r0 !== 3) begin bad++; $display("FAIL b2b_reads reads=%0d required 3", rdPulses - r0); end
    @(negedge Clk);
  endtask

  task automatic test_underrun();
    int wc, lc, r0;
    logic [63:0] b;
    push(16'h1234); push(16'hBEEF);
    r0 = rdPulses;
    start_frame(4);
    capture_frame(wc, lc, b);
    total++; if (lc !== 32) begin bad++; $display("FAIL under_low low=%0d required 32", lc); end
    total++; if (b[31:0] !== 32'hEDCB_4110) begin bad++; $display("FAIL under_bits got=%h required edcb4110", b[31:0]); end
    total++; if (TransmitDone !== 1'b1 || Underrun !== 1'b1 || WordsSent !== 12'd2) begin bad++; $display("FAIL under_done Done=%b Underrun=%b WordsSent=%0d required 1 1 2", TransmitDone, Underrun, WordsSent); end
    total++; if (rdPulses - r0 !== 2) begin bad++; $display("FAIL under_reads reads=%0d required 2", rdPulses - r0); end
    @(negedge Clk);
    total++; if (Underrun !== 1'b1) begin bad++; $display("FAIL under_sticky Underrun=%b required 1", Underrun); end
    push(16'h0F0F);
    start_frame(1);
    total++; if (Underrun !== 1'b0 || WordsSent !== 12'd0) begin bad++; $display("FAIL under_clear Underrun=%b WordsSent=%0d required 0 0", Underrun, WordsSent); end
    @(negedge Clk);
    capture_frame(wc, lc, b);
    total++; if (lc !== 16 || b[15:0] !== 16'hF0F0) begin bad++; $display("FAIL under_next low=%0d bits=%h required 16 f0f0", lc, b[15:0]); end
    @(negedge Clk);
  endtask

  task automatic test_edge_starts();
    int r0, lowSeen;
    // Empty FIFO at Start
    r0 = rdPulses;
    start_frame(2);
    total++; if (TransmitDone !== 1'b1 || Underrun !== 1'b1 || FifoReadEn !== 1'b0) begin bad++; $display("FAIL empty_start Done=%b Underrun=%b ReadEn=%b required 1 1 0", TransmitDone, Underrun, FifoReadEn); end
    @(negedge Clk);
    total++; if (Busy !== 1'b0 || rdPulses - r0 !== 0) begin bad++; $display("FAIL empty_idle Busy=%b reads=%0d required 0 0", Busy, rdPulses - r0); end
    // Zero-length frame with data waiting
    push(16'h3C3C);
    r0 = rdPulses;
    lowSeen = 0;
    start_frame(0);
    total++; if (TransmitDone !== 1'b1 || Underrun !== 1'b0 || FifoReadEn !== 1'b0) begin bad++; $display("FAIL zero_start Done=%b Underrun=%b ReadEn=%b required 1 0 0", TransmitDone, Underrun, FifoReadEn); end
    repeat (4) begin
      if (TransmitOn !== 1'b1) lowSeen++;
      @(negedge Clk);
    end
    total++; if (lowSeen !== 0 || rdPulses - r0 !== 0 || Busy !== 1'b0) begin bad++; $display("FAIL zero_quiet low=%0d reads=%0d Busy=%b required 0 0 0", lowSeen, rdPulses - r0, Busy); end
  endtask

  task automatic test_reset_mid_frame();
    int wc, lc;
    logic [63:0] b;
    push(16'h5555);
    start_frame(2);
    // From N+1, advance to N+26 = bit 7 of the second word
    repeat (25) @(negedge Clk);
    total++; if (TransmitOn !== 1'b0 || WordsSent !== 12'd1) begin bad++; $display("FAIL midrst_pre TransmitOn=%b WordsSent=%0d required 0 1", TransmitOn, WordsSent); end
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    total++; if (TransmitOn !== 1'b1 || AsicDout !== 1'b1 || Busy !== 1'b0) begin bad++; $display("FAIL midrst_line TransmitOn=%b AsicDout=%b Busy=%b required 1 1 0", TransmitOn, AsicDout, Busy); end
    total++; if (WordsSent !== 12'd0 || TransmitDone !== 1'b0) begin bad++; $display("FAIL midrst_stat WordsSent=%0d Done=%b required 0 0", WordsSent, TransmitDone); end
    @(negedge Clk);
    total++; if (TransmitDone !== 1'b0) begin bad++; $display("FAIL midrst_nodone Done=%b required 0", TransmitDone); end
    push(16'h00FF);
    start_frame(1);
    @(negedge Clk);
    capture_frame(wc, lc, b);
    total++; if (lc !== 16 || b[15:0] !== 16'hFF00) begin bad++; $display("FAIL midrst_restart low=%0d bits=%h required 16 ff00", lc, b[15:0]); end
    total++; if (TransmitDone !== 1'b1 || WordsSent !== 12'd1) begin bad++; $display("FAIL midrst_done Done=%b WordsSent=%0d required 1 1", TransmitDone, WordsSent); end
    @(negedge Clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    wrPtr = 0;
    rdPtr = 0;
    rdPulses = 0;
    reset = 1'b1;
    Start = 1'b0;
    FrameWords = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_edge_starts();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
